// File: rtl/axi_lite_wr_arbiter.sv
// Two-master round-robin arbiter for a single AXI-Lite write port.
// Only one AW/W/B transaction is in flight at a time. The granted master's
// channels are muxed to the slave. The other master sees its readies and
// bvalid held low.
module axi_lite_wr_arbiter #(
  parameter  int AXI_ADDR_WIDTH = 20,
  parameter  int AXI_DATA_WIDTH = 16,
  localparam int STRB_W         = (AXI_DATA_WIDTH + 7) / 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [AXI_ADDR_WIDTH-1:0] m0_axi_awaddr,
  input  logic                      m0_axi_awvalid,
  output logic                      m0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] m0_axi_wdata,
  input  logic [STRB_W-1:0]         m0_axi_wstrb,
  input  logic                      m0_axi_wvalid,
  output logic                      m0_axi_wready,
  output logic [1:0]                m0_axi_bresp,
  output logic                      m0_axi_bvalid,
  input  logic                      m0_axi_bready,

  input  logic [AXI_ADDR_WIDTH-1:0] m1_axi_awaddr,
  input  logic                      m1_axi_awvalid,
  output logic                      m1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] m1_axi_wdata,
  input  logic [STRB_W-1:0]         m1_axi_wstrb,
  input  logic                      m1_axi_wvalid,
  output logic                      m1_axi_wready,
  output logic [1:0]                m1_axi_bresp,
  output logic                      m1_axi_bvalid,
  input  logic                      m1_axi_bready,

  output logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic                      s_axi_awvalid,
  input  logic                      s_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  output logic [STRB_W-1:0]         s_axi_wstrb,
  output logic                      s_axi_wvalid,
  input  logic                      s_axi_wready,
  input  logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_bvalid,
  output logic                      s_axi_bready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic                      req0, req1;
  logic                      in_ad, in_resp;
  logic [AXI_ADDR_WIDTH-1:0] g_awaddr;
  logic [AXI_DATA_WIDTH-1:0] g_wdata;
  logic [STRB_W-1:0]         g_wstrb;
  logic                      g_awvalid, g_wvalid, g_bready;
  logic                      g_awready, g_wready, g_bvalid;
  logic                      aw_hs, w_hs, b_hs;
  logic                      aw_now, w_now;

  // A master requests as soon as either its address or its data is valid,
  // so a data-first master is still granted.
  assign req0 = m0_axi_awvalid | m0_axi_wvalid;
  assign req1 = m1_axi_awvalid | m1_axi_wvalid;

  assign in_ad   = (state_q == ADDR_DATA);
  assign in_resp = (state_q == RESP);

  // Granted-master view of the request channels.
  assign g_awaddr  = grant_q ? m1_axi_awaddr  : m0_axi_awaddr;
  assign g_wdata   = grant_q ? m1_axi_wdata   : m0_axi_wdata;
  assign g_wstrb   = grant_q ? m1_axi_wstrb   : m0_axi_wstrb;
  assign g_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
  assign g_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
  assign g_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;

  // Each channel is forwarded only until its handshake completes, so a master
  // that keeps its valid high cannot cause a duplicate AW or W beat.
  assign s_axi_awaddr  = g_awaddr;
  assign s_axi_wdata   = g_wdata;
  assign s_axi_wstrb   = g_wstrb;
  assign s_axi_awvalid = in_ad & g_awvalid & ~aw_done_q;
  assign s_axi_wvalid  = in_ad & g_wvalid  & ~w_done_q;
  assign g_awready     = in_ad & s_axi_awready & ~aw_done_q;
  assign g_wready      = in_ad & s_axi_wready  & ~w_done_q;

  // A slave bvalid seen outside RESP is not acknowledged.
  assign g_bvalid     = in_resp & s_axi_bvalid;
  assign s_axi_bready = in_resp & g_bready;

  assign m0_axi_awready = g_awready & ~grant_q;
  assign m1_axi_awready = g_awready &  grant_q;
  assign m0_axi_wready  = g_wready  & ~grant_q;
  assign m1_axi_wready  = g_wready  &  grant_q;
  assign m0_axi_bvalid  = g_bvalid  & ~grant_q;
  assign m1_axi_bvalid  = g_bvalid  &  grant_q;
  assign m0_axi_bresp   = (in_resp && !grant_q) ? s_axi_bresp : 2'b00;
  assign m1_axi_bresp   = (in_resp &&  grant_q) ? s_axi_bresp : 2'b00;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid  & s_axi_wready;
  assign b_hs   = s_axi_bvalid  & s_axi_bready;
  assign aw_now = aw_done_q | aw_hs;
  assign w_now  = w_done_q  | w_hs;

  // Next-state logic: arbitrate in IDLE, track AW/W completion, wait for B.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ADDR_DATA;
          if (req0 && req1) grant_d = ~last_grant_q;
          else              grant_d = req1;
        end
      end
      ADDR_DATA: begin
        if (aw_now && w_now) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      RESP: begin
        if (b_hs) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Directed bench for axi_lite_wr_arbiter. Inputs change 1ns after each rising
// edge; combinational outputs are checked 1ns later, well before the next edge.
module tb_axi_lite_wr_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SW = (DW + 7) / 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] m0_axi_awaddr, m1_axi_awaddr, s_axi_awaddr;
  logic          m0_axi_awvalid, m1_axi_awvalid, s_axi_awvalid;
  logic          m0_axi_awready, m1_axi_awready, s_axi_awready;
  logic [DW-1:0] m0_axi_wdata, m1_axi_wdata, s_axi_wdata;
  logic [SW-1:0] m0_axi_wstrb, m1_axi_wstrb, s_axi_wstrb;
  logic          m0_axi_wvalid, m1_axi_wvalid, s_axi_wvalid;
  logic          m0_axi_wready, m1_axi_wready, s_axi_wready;
  logic [1:0]    m0_axi_bresp, m1_axi_bresp, s_axi_bresp;
  logic          m0_axi_bvalid, m1_axi_bvalid, s_axi_bvalid;
  logic          m0_axi_bready, m1_axi_bready, s_axi_bready;

  int total = 0;
  int bad   = 0;
  int i0, i1;

  axi_lite_wr_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid),
    .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid),
    .m0_axi_bready(m0_axi_bready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid),
    .m1_axi_wready(m1_axi_wready), .m1_axi_bresp(m1_axi_bresp), .m1_axi_bvalid(m1_axi_bvalid),
    .m1_axi_bready(m1_axi_bready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every valid/ready/bvalid output low (the IDLE / reset picture).
  task automatic chk_quiet(input string tag);
    chk({tag, "_s_awvalid"}, 32'(s_axi_awvalid), 0);
    chk({tag, "_s_wvalid"},  32'(s_axi_wvalid),  0);
    chk({tag, "_s_bready"},  32'(s_axi_bready),  0);
    chk({tag, "_m0_awready"}, 32'(m0_axi_awready), 0);
    chk({tag, "_m0_wready"},  32'(m0_axi_wready),  0);
    chk({tag, "_m0_bvalid"},  32'(m0_axi_bvalid),  0);
    chk({tag, "_m1_awready"}, 32'(m1_axi_awready), 0);
    chk({tag, "_m1_wready"},  32'(m1_axi_wready),  0);
    chk({tag, "_m1_bvalid"},  32'(m1_axi_bvalid),  0);
  endtask

  initial begin
    reset = 1'b0;
    m0_axi_awaddr = '0; m0_axi_awvalid = 0; m0_axi_wdata = '0; m0_axi_wstrb = '0;
    m0_axi_wvalid = 0;  m0_axi_bready = 0;
    m1_axi_awaddr = '0; m1_axi_awvalid = 0; m1_axi_wdata = '0; m1_axi_wstrb = '0;
    m1_axi_wvalid = 0;  m1_axi_bready = 0;
    s_axi_awready = 0; s_axi_wready = 0; s_axi_bresp = 2'b00; s_axi_bvalid = 0;

    // Reset, with a pending request and slave bvalid that must be ignored.
    tick(); tick();
    m0_axi_awvalid = 1; s_axi_bvalid = 1; s_axi_awready = 1;
    #1;
    chk_quiet("rst");
    m0_axi_awvalid = 0; s_axi_bvalid = 0;
    reset = 1'b1;

    // ---- M0 only, slave always ready ----
    tick();
    m0_axi_awaddr = 20'h00123; m0_axi_wdata = 16'hF000; m0_axi_wstrb = 2'b11;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1; m0_axi_bready = 1;
    s_axi_awready = 1; s_axi_wready = 1; s_axi_bvalid = 1; s_axi_bresp = 2'b00;
    #1;
    chk_quiet("t1_idle");
    tick();
    chk("t1_s_awvalid", 32'(s_axi_awvalid), 1);
    chk("t1_s_wvalid",  32'(s_axi_wvalid),  1);
    chk("t1_s_awaddr",  32'(s_axi_awaddr),  32'h00123);
    chk("t1_s_wdata",   32'(s_axi_wdata),   32'hF000);
    chk("t1_s_wstrb",   32'(s_axi_wstrb),   32'h3);
    chk("t1_m0_awready", 32'(m0_axi_awready), 1);
    chk("t1_m0_wready",  32'(m0_axi_wready),  1);
    chk("t1_m1_awready", 32'(m1_axi_awready), 0);
    chk("t1_m1_wready",  32'(m1_axi_wready),  0);
    chk("t1_m0_bvalid_ad", 32'(m0_axi_bvalid), 0);
    tick();
    m0_axi_awvalid = 0; m0_axi_wvalid = 0;
    #1;
    chk("t1_m0_bvalid", 32'(m0_axi_bvalid), 1);
    chk("t1_m0_bresp",  32'(m0_axi_bresp),  0);
    chk("t1_s_bready",  32'(s_axi_bready),  1);
    chk("t1_s_awvalid_resp", 32'(s_axi_awvalid), 0);
    chk("t1_m1_bvalid", 32'(m1_axi_bvalid), 0);
    tick();
    chk("t1_m0_bvalid_idle", 32'(m0_axi_bvalid), 0);
    chk("t1_s_bready_idle",  32'(s_axi_bready),  0);

    // ---- Both masters from reset, 4 writes each ----
    reset = 1'b0;
    tick();
    reset = 1'b1;
    i0 = 0; i1 = 0;
    m0_axi_awaddr = 20'h00000; m0_axi_wdata = 16'hA000;
    m1_axi_awaddr = 20'h00100; m1_axi_wdata = 16'hB000; m1_axi_wstrb = 2'b11;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1; m1_axi_awvalid = 1; m1_axi_wvalid = 1;
    m1_axi_bready = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if ((k % 2) == 0) begin
        chk("t2_m0_awaddr", 32'(s_axi_awaddr), 32'(i0));
        chk("t2_m0_wdata",  32'(s_axi_wdata),  32'h0000A000 + 32'(i0));
        chk("t2_m0_awready", 32'(m0_axi_awready), 1);
        chk("t2_m1_awready_off", 32'(m1_axi_awready), 0);
        chk("t2_m1_wready_off",  32'(m1_axi_wready),  0);
      end else begin
        chk("t2_m1_awaddr", 32'(s_axi_awaddr), 32'h100 + 32'(i1));
        chk("t2_m1_wdata",  32'(s_axi_wdata),  32'h0000B000 + 32'(i1));
        chk("t2_m1_awready", 32'(m1_axi_awready), 1);
        chk("t2_m0_awready_off", 32'(m0_axi_awready), 0);
        chk("t2_m0_wready_off",  32'(m0_axi_wready),  0);
      end
      tick();
      if ((k % 2) == 0) i0++; else i1++;
      m0_axi_awaddr = 20'(i0);         m0_axi_wdata = 16'hA000 + 16'(i0);
      m1_axi_awaddr = 20'h100 + 20'(i1); m1_axi_wdata = 16'hB000 + 16'(i1);
      m0_axi_awvalid = (i0 < 4); m0_axi_wvalid = (i0 < 4);
      m1_axi_awvalid = (i1 < 4); m1_axi_wvalid = (i1 < 4);
      #1;
      chk("t2_m0_bvalid", 32'(m0_axi_bvalid), ((k % 2) == 0) ? 32'd1 : 32'd0);
      chk("t2_m1_bvalid", 32'(m1_axi_bvalid), ((k % 2) == 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t2_done_i0", 32'(i0), 4);
    chk("t2_done_i1", 32'(i1), 4);

    // ---- Slave delays wready by 3 cycles ----
    m0_axi_awaddr = 20'h00055; m0_axi_wdata = 16'h1234;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1;
    s_axi_awready = 1; s_axi_wready = 0; s_axi_bvalid = 0;
    tick();
    chk("t3_s_awvalid_c1", 32'(s_axi_awvalid), 1);
    chk("t3_s_wvalid_c1",  32'(s_axi_wvalid),  1);
    chk("t3_m0_wready_c1", 32'(m0_axi_wready), 0);
    tick();
    chk("t3_s_awvalid_c2", 32'(s_axi_awvalid), 0);
    chk("t3_m0_awready_c2", 32'(m0_axi_awready), 0);
    chk("t3_s_wvalid_c2",  32'(s_axi_wvalid),  1);
    tick();
    s_axi_wready = 1;
    #1;
    chk("t3_s_awvalid_c3", 32'(s_axi_awvalid), 0);
    chk("t3_s_wvalid_c3",  32'(s_axi_wvalid),  1);
    chk("t3_m0_wready_c3", 32'(m0_axi_wready), 1);
    chk("t3_s_wdata",      32'(s_axi_wdata),   32'h1234);
    tick();
    m0_axi_awvalid = 0; m0_axi_wvalid = 0; s_axi_bvalid = 1;
    #1;
    chk("t3_s_wvalid_resp", 32'(s_axi_wvalid), 0);
    chk("t3_m0_bvalid",     32'(m0_axi_bvalid), 1);
    tick();
    s_axi_bvalid = 0;

    // ---- M1 presents W two cycles before AW ----
    m1_axi_awaddr = 20'h00321; m1_axi_wdata = 16'hC0DE;
    m1_axi_wvalid = 1; m1_axi_awvalid = 0;
    #1;
    chk("t4_idle_s_wvalid", 32'(s_axi_wvalid), 0);
    tick();
    chk("t4_s_wvalid_c1",  32'(s_axi_wvalid),  1);
    chk("t4_s_awvalid_c1", 32'(s_axi_awvalid), 0);
    chk("t4_m1_wready_c1", 32'(m1_axi_wready), 1);
    chk("t4_m0_wready_c1", 32'(m0_axi_wready), 0);
    chk("t4_s_wdata",      32'(s_axi_wdata),   32'hC0DE);
    tick();
    m1_axi_awvalid = 1;
    #1;
    chk("t4_s_wvalid_c2",  32'(s_axi_wvalid),  0);
    chk("t4_m1_wready_c2", 32'(m1_axi_wready), 0);
    chk("t4_s_awvalid_c2", 32'(s_axi_awvalid), 1);
    chk("t4_s_awaddr",     32'(s_axi_awaddr),  32'h00321);
    chk("t4_m1_awready",   32'(m1_axi_awready), 1);
    tick();
    m1_axi_awvalid = 0; m1_axi_wvalid = 0; s_axi_bvalid = 1;
    #1;
    chk("t4_m1_bvalid", 32'(m1_axi_bvalid), 1);
    chk("t4_m0_bvalid", 32'(m0_axi_bvalid), 0);
    tick();

    // ---- Error response with M0 stalling bready, M1 pending ----
    m0_axi_awaddr = 20'h00777; m0_axi_wdata = 16'h7777;
    m1_axi_awaddr = 20'h00888; m1_axi_wdata = 16'h8888;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1; m0_axi_bready = 0;
    m1_axi_awvalid = 1; m1_axi_wvalid = 1; m1_axi_bready = 0;
    s_axi_bvalid = 1; s_axi_bresp = 2'b10;
    #1;
    chk("t5_idle_s_bready",  32'(s_axi_bready),  0);
    chk("t5_idle_m0_bvalid", 32'(m0_axi_bvalid), 0);
    tick();
    chk("t5_s_awaddr",       32'(s_axi_awaddr),   32'h00777);
    chk("t5_m1_awready_off", 32'(m1_axi_awready), 0);
    tick();
    m0_axi_awvalid = 0; m0_axi_wvalid = 0;
    #1;
    chk("t5_m0_bvalid_c1", 32'(m0_axi_bvalid), 1);
    chk("t5_m0_bresp_c1",  32'(m0_axi_bresp),  2);
    chk("t5_s_bready_c1",  32'(s_axi_bready),  0);
    chk("t5_m1_bresp",     32'(m1_axi_bresp),  0);
    chk("t5_m1_bvalid",    32'(m1_axi_bvalid), 0);
    tick();
    chk("t5_m0_bvalid_c2", 32'(m0_axi_bvalid), 1);
    chk("t5_m0_bresp_c2",  32'(m0_axi_bresp),  2);
    m0_axi_bready = 1;
    #1;
    chk("t5_s_bready_c3",  32'(s_axi_bready),  1);
    tick();
    chk("t5_m0_bvalid_idle", 32'(m0_axi_bvalid), 0);
    chk("t5_s_awvalid_idle", 32'(s_axi_awvalid), 0);
    tick();
    chk("t5_next_awaddr",  32'(s_axi_awaddr),   32'h00888);
    chk("t5_m1_awready",   32'(m1_axi_awready), 1);
    chk("t5_m0_awready",   32'(m0_axi_awready), 0);

    // ---- Reset during RESP, then a tie goes to M0 ----
    tick();
    m1_axi_awvalid = 0; m1_axi_wvalid = 0;
    #1;
    chk("t6_m1_bvalid_resp", 32'(m1_axi_bvalid), 1);
    reset = 1'b0;
    tick();
    m0_axi_awaddr = 20'h00AAA; m1_axi_awaddr = 20'h00BBB;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1; m1_axi_awvalid = 1; m1_axi_wvalid = 1;
    #1;
    chk_quiet("t6_rst");
    chk("t6_m1_bresp", 32'(m1_axi_bresp), 0);
    reset = 1'b1;
    tick();
    chk("t6_tie_awaddr",  32'(s_axi_awaddr),   32'h00AAA);
    chk("t6_m0_awready",  32'(m0_axi_awready), 1);
    chk("t6_m1_awready",  32'(m1_axi_awready), 0);
    tick();
    m0_axi_awvalid = 0; m0_axi_wvalid = 0;
    #1;
    chk("t6_m0_bvalid",   32'(m0_axi_bvalid), 1);
    chk("t6_m0_bresp",    32'(m0_axi_bresp),  2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
